// File: rtl/dsp_be_prbs_chk.sv
// ---------------------------------------------------------------------------
// dsp_be_prbs_chk
//   Self-synchronizing PRBS checker for the parallel output of the MLSE
//   decoder. Expected bit n of the stream is r[n-tap_a] ^ r[n-tap_b]. r is
//   the post-inversion stream, so no seeding step is needed. The 31 MSBs of
//   the previous valid word supply the taps that reach back across the word
//   boundary.
//
//   Pipeline for a valid word sampled at the edge that ends cycle N:
//     cycle N+1 : registered mismatch vector + valid         (stage 1)
//     cycle N+2 : registered popcount, o_err_word, FSM and counters
//
//   Handshake: i_en is a plain qualifier with no back-pressure. A word is
//   consumed on every rising edge where i_en=1. Gaps are allowed. An idle
//   cycle moves nothing through the FSM or the counters.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous, active-high reset
//   i_en           i_drx holds a valid word this cycle
//   i_drx          decoded bits, bit 0 earliest in time
//   i_cfg_prbs_sel 0=PRBS7, 1=PRBS15, 2/3=PRBS31
//   i_cfg_inv      invert i_drx before checking
//   i_clr_cnt      zero both counters on the next edge
//   o_lock         FSM is in LOCK
//   o_err_word     one-cycle pulse per valid word with >=1 mismatch
//   o_err_cnt      saturating bit-error count while locked
//   o_word_cnt     saturating checked-word count while locked
//   o_dbg_state    FSM state (0=UNLOCK, 1=LOCK)
//   o_dbg_pop_vld  stage-2 valid
//   o_dbg_pop      stage-2 popcount
// ---------------------------------------------------------------------------
module dsp_be_prbs_chk #(
   parameter int PRLL_RANK     = 64,
   parameter int LOCK_THRESH   = 16,
   parameter int UNLOCK_THRESH = 16,
   localparam int POP_W        = $clog2(PRLL_RANK + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic [PRLL_RANK-1:0] i_drx,
   input  logic [1:0]           i_cfg_prbs_sel,
   input  logic                 i_cfg_inv,
   input  logic                 i_clr_cnt,
   output logic                 o_lock,
   output logic                 o_err_word,
   output logic [31:0]          o_err_cnt,
   output logic [31:0]          o_word_cnt,
   output logic                 o_dbg_state,
   output logic                 o_dbg_pop_vld,
   output logic [POP_W-1:0]     o_dbg_pop
);

   localparam int HIST_W  = 31;
   localparam int CLEAN_W = $clog2(LOCK_THRESH + 1);

   typedef enum logic {
      ST_UNLOCK = 1'b0,
      ST_LOCK   = 1'b1
   } state_t;

   state_t               state;
   logic [CLEAN_W-1:0]   clean_cnt;
   logic [HIST_W-1:0]    hist;
   logic [1:0]           sel_q;
   logic                 inv_q;
   logic                 cfg_chg;
   logic [4:0]           tap_a;
   logic [4:0]           tap_b;
   logic [PRLL_RANK-1:0] post;
   logic [PRLL_RANK+HIST_W-1:0] stream;
   logic [PRLL_RANK-1:0] exp_a;
   logic [PRLL_RANK-1:0] exp_b;
   logic [PRLL_RANK-1:0] mis;
   logic                 s1_valid;
   logic [PRLL_RANK-1:0] s1_mis;
   logic [POP_W-1:0]     pop;
   logic                 use_word;
   logic [32:0]          err_sum;
   logic [32:0]          word_sum;

   // ---------------- tap selection ----------------
   always_comb begin
      tap_a = 5'd28;
      tap_b = 5'd31;
      case (i_cfg_prbs_sel)
         2'd0:    begin tap_a = 5'd6;  tap_b = 5'd7;  end
         2'd1:    begin tap_a = 5'd14; tap_b = 5'd15; end
         default: begin tap_a = 5'd28; tap_b = 5'd31; end
      endcase
   end

   // ---------------- mismatch vector ----------------
   // stream[HIST_W + k] is current bit k, and stream[j] for j < HIST_W is
   // history. Shifting right by (31 - tap) lines up bit k-tap with bit k.
   assign post   = i_drx ^ {PRLL_RANK{i_cfg_inv}};
   assign stream = {post, hist};
   assign exp_a  = PRLL_RANK'(stream >> (5'd31 - tap_a));
   assign exp_b  = PRLL_RANK'(stream >> (5'd31 - tap_b));
   assign mis    = post ^ exp_a ^ exp_b;

   // A config change kills the word entering stage 1 and the word leaving it.
   assign cfg_chg  = (i_cfg_prbs_sel != sel_q) || (i_cfg_inv != inv_q);
   assign use_word = s1_valid && !cfg_chg;

   always_comb begin
      pop = '0;
      for (int k = 0; k < PRLL_RANK; k++) begin
         pop = pop + POP_W'(s1_mis[k]);
      end
   end

   // The registered copy of the config is reloaded every cycle, including
   // during reset, so a static config never looks like a change.
   always_ff @(posedge i_clk) begin
      sel_q <= i_cfg_prbs_sel;
      inv_q <= i_cfg_inv;
   end

   // ---------------- pipeline + history ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hist          <= '0;
         s1_valid      <= 1'b0;
         s1_mis        <= '0;
         o_dbg_pop_vld <= 1'b0;
         o_dbg_pop     <= '0;
         o_err_word    <= 1'b0;
      end else begin
         if (i_en) begin
            hist   <= post[PRLL_RANK-1 -: HIST_W];
            s1_mis <= mis;
         end
         s1_valid      <= i_en && !cfg_chg;
         o_dbg_pop_vld <= use_word;
         o_dbg_pop     <= pop;
         o_err_word    <= use_word && (pop != '0);
      end
   end

   // ---------------- lock FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_UNLOCK;
         clean_cnt <= '0;
      end else if (cfg_chg) begin
         state     <= ST_UNLOCK;
         clean_cnt <= '0;
      end else if (use_word) begin
         case (state)
            ST_UNLOCK: begin
               if (pop == '0) begin
                  if (clean_cnt == CLEAN_W'(LOCK_THRESH - 1)) begin
                     state     <= ST_LOCK;
                     clean_cnt <= '0;
                  end else begin
                     clean_cnt <= clean_cnt + CLEAN_W'(1);
                  end
               end else begin
                  clean_cnt <= '0;
               end
            end
            ST_LOCK: begin
               if (int'(pop) >= UNLOCK_THRESH) begin
                  state <= ST_UNLOCK;
               end
            end
            default: state <= ST_UNLOCK;
         endcase
      end
   end

   assign o_lock      = (state == ST_LOCK);
   assign o_dbg_state = state;

   // ---------------- saturating counters ----------------
   // The counters look at the state as it was before this edge. The word
   // that completes lock is therefore not counted, and the word that breaks
   // lock is.
   assign err_sum  = {1'b0, o_err_cnt} + 33'(pop);
   assign word_sum = {1'b0, o_word_cnt} + 33'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr_cnt) begin
         o_err_cnt  <= '0;
         o_word_cnt <= '0;
      end else if (use_word && (state == ST_LOCK)) begin
         o_err_cnt  <= err_sum[32]  ? 32'hFFFF_FFFF : err_sum[31:0];
         o_word_cnt <= word_sum[32] ? 32'hFFFF_FFFF : word_sum[31:0];
      end
   end

endmodule

// File: tb/tb_dsp_be_prbs_chk.sv
// ---------------------------------------------------------------------------
// tb_dsp_be_prbs_chk
//   Directed sequence with randomized PRBS seeds, error words and i_en gaps.
//   The reference model works on a bit queue of the received stream. It
//   holds one pending-word slot and runs the lock and counter rules written
//   as plain arithmetic. Every output is compared after every rising edge.
// ---------------------------------------------------------------------------
module tb_dsp_be_prbs_chk;
   localparam int W    = 64;
   localparam int LT   = 16;
   localparam int UT   = 16;
   localparam int PW   = $clog2(W + 1);
   localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic          i_rst = 1'b1;
   logic          i_en = 1'b0;
   logic [W-1:0]  i_drx = '0;
   logic [1:0]    i_cfg_prbs_sel = 2'd2;
   logic          i_cfg_inv = 1'b0;
   logic          i_clr_cnt = 1'b0;
   logic          o_lock;
   logic          o_err_word;
   logic [31:0]   o_err_cnt;
   logic [31:0]   o_word_cnt;
   logic          o_dbg_state;
   logic          o_dbg_pop_vld;
   logic [PW-1:0] o_dbg_pop;

   dsp_be_prbs_chk #(
      .PRLL_RANK    (W),
      .LOCK_THRESH  (LT),
      .UNLOCK_THRESH(UT)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_en          (i_en),
      .i_drx         (i_drx),
      .i_cfg_prbs_sel(i_cfg_prbs_sel),
      .i_cfg_inv     (i_cfg_inv),
      .i_clr_cnt     (i_clr_cnt),
      .o_lock        (o_lock),
      .o_err_word    (o_err_word),
      .o_err_cnt     (o_err_cnt),
      .o_word_cnt    (o_word_cnt),
      .o_dbg_state   (o_dbg_state),
      .o_dbg_pop_vld (o_dbg_pop_vld),
      .o_dbg_pop     (o_dbg_pop)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- stimulus generator ----------------
   bit gen_q[$];

   function automatic void taps_of(input logic [1:0] s, output int ta, output int tb);
      case (s)
         2'd0:    begin ta = 6;  tb = 7;  end
         2'd1:    begin ta = 14; tb = 15; end
         default: begin ta = 28; tb = 31; end
      endcase
   endfunction

   task automatic reseed();
      gen_q.delete();
      for (int i = 0; i < 31; i++) gen_q.push_back(bit'($urandom_range(1, 0)));
      gen_q[30] = 1'b1;
   endtask

   task automatic gen_word(input logic [1:0] s, output logic [W-1:0] w);
      int ta, tb;
      bit b;
      taps_of(s, ta, tb);
      for (int k = 0; k < W; k++) begin
         b = gen_q[gen_q.size() - ta] ^ gen_q[gen_q.size() - tb];
         gen_q.push_back(b);
         w[k] = b;
      end
      while (gen_q.size() > 31) void'(gen_q.pop_front());
   endtask

   // ---------------- reference model ----------------
   bit         m_hist[$];
   logic [1:0] m_sel_q = 2'd2;
   logic       m_inv_q = 1'b0;
   bit         m_pend_v = 0;
   int         m_pend_pop = 0;
   bit         m_lock = 0;
   int         m_clean = 0;
   longint     m_errc = 0;
   longint     m_wordc = 0;
   bit         m_errw = 0;

   task automatic model_edge();
      int  ta, tb, cnt, cons_pop;
      bit  chg, cons_v, p, e;
      if (i_rst) begin
         m_hist.delete();
         repeat (31) m_hist.push_back(1'b0);
         m_pend_v = 0; m_pend_pop = 0;
         m_lock = 0; m_clean = 0;
         m_errc = 0; m_wordc = 0; m_errw = 0;
      end else begin
         chg      = (i_cfg_prbs_sel != m_sel_q) || (i_cfg_inv != m_inv_q);
         cons_v   = m_pend_v && !chg;
         cons_pop = m_pend_pop;
         cnt = 0;
         if (i_en) begin
            taps_of(i_cfg_prbs_sel, ta, tb);
            for (int k = 0; k < W; k++) begin
               p = i_drx[k] ^ i_cfg_inv;
               e = m_hist[m_hist.size() - ta] ^ m_hist[m_hist.size() - tb];
               if (p != e) cnt++;
               m_hist.push_back(p);
            end
            while (m_hist.size() > 31) void'(m_hist.pop_front());
         end
         m_pend_v   = i_en && !chg;
         m_pend_pop = cnt;
         m_errw     = cons_v && (cons_pop > 0);
         if (i_clr_cnt) begin
            m_errc = 0; m_wordc = 0;
         end else if (cons_v && m_lock) begin
            m_errc  = (m_errc + cons_pop > MAXC) ? MAXC : m_errc + cons_pop;
            m_wordc = (m_wordc + 1 > MAXC) ? MAXC : m_wordc + 1;
         end
         if (chg) begin
            m_lock = 0; m_clean = 0;
         end else if (cons_v) begin
            if (!m_lock) begin
               if (cons_pop == 0) begin
                  m_clean++;
                  if (m_clean == LT) begin m_lock = 1; m_clean = 0; end
               end else begin
                  m_clean = 0;
               end
            end else if (cons_pop >= UT) begin
               m_lock = 0;
            end
         end
      end
      m_sel_q = i_cfg_prbs_sel;
      m_inv_q = i_cfg_inv;
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_edge();
      #1;
      chk("lock",     32'(o_lock),      32'(m_lock));
      chk("dbg_state",32'(o_dbg_state), 32'(m_lock));
      chk("err_word", 32'(o_err_word),  32'(m_errw));
      chk("err_cnt",  o_err_cnt,        32'(m_errc));
      chk("word_cnt", o_word_cnt,       32'(m_wordc));
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_prbs(input int n, input logic [W-1:0] flip);
      logic [W-1:0] w;
      for (int i = 0; i < n; i++) begin
         gen_word(i_cfg_prbs_sel, w);
         i_en  = 1'b1;
         i_drx = w ^ flip ^ {W{i_cfg_inv}};
         tick();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         i_en = 1'b0;
         tick();
      end
   endtask

   task automatic wait_lock(input string tag, input int max_words, output int n);
      n = 0;
      while (!o_lock && n < max_words) begin
         send_prbs(1, '0);
         n++;
      end
      chk(tag, 32'(o_lock), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      bit saw_lock;
      logic [31:0] e0, wc0;

      reseed();
      i_rst = 1'b1;
      idle(3);
      chk("rst_lock",    32'(o_lock),     32'd0);
      chk("rst_err_word",32'(o_err_word), 32'd0);
      chk("rst_err_cnt", o_err_cnt,       32'd0);
      chk("rst_word_cnt",o_word_cnt,      32'd0);

      // Clean PRBS31, continuous enable.
      i_rst = 1'b0;
      wait_lock("acq31", 40, n);
      chk("acq31_within", 32'(n <= 2 + LT + 1), 32'd1);
      wc0 = o_word_cnt;
      send_prbs(20, '0);
      chk("acq31_words", o_word_cnt - wc0, 32'd20);
      chk("acq31_noerr", o_err_cnt, 32'd0);

      // Single bit flip: three errors, all inside the same word.
      e0 = o_err_cnt;
      send_prbs(1, 64'h1 << $urandom_range(20, 0));
      chk("flip_pre",  32'(o_err_word), 32'd0);
      send_prbs(1, '0);
      chk("flip_pulse",32'(o_err_word), 32'd1);
      send_prbs(1, '0);
      chk("flip_post", 32'(o_err_word), 32'd0);
      chk("flip_cnt",  o_err_cnt, e0 + 32'd3);
      chk("flip_lock", 32'(o_lock), 32'd1);

      // Random word breaks lock, then re-lock.
      e0 = o_err_cnt;
      i_en = 1'b1;
      i_drx = {$urandom, $urandom};
      tick();
      send_prbs(1, '0);
      chk("rand_unlock", 32'(o_lock), 32'd0);
      chk("rand_errs",   32'(o_err_cnt >= e0 + 32'd16), 32'd1);
      wait_lock("rand_relock", 30, n);

      // Inversion change while locked.
      wc0 = o_word_cnt;
      i_cfg_inv = 1'b1;
      send_prbs(1, '0);
      chk("inv_unlock", 32'(o_lock), 32'd0);
      chk("inv_keep",   o_word_cnt, wc0);
      wait_lock("inv_relock", 30, n);

      // Saturation, then clear racing an error word.
      idle(2);
      force dut.o_err_cnt  = 32'hFFFF_FFF0;
      force dut.o_word_cnt = 32'hFFFF_FFFD;
      #1;
      release dut.o_err_cnt;
      release dut.o_word_cnt;
      m_errc  = 64'hFFFF_FFF0;
      m_wordc = 64'hFFFF_FFFD;
      for (int i = 0; i < 8; i++) begin
         send_prbs(1, 64'h1 << $urandom_range(30, 0));
         send_prbs(1, '0);
      end
      chk("sat_err",  o_err_cnt,  32'hFFFF_FFFF);
      chk("sat_word", o_word_cnt, 32'hFFFF_FFFF);
      chk("sat_lock", 32'(o_lock), 32'd1);
      send_prbs(1, 64'h1 << 3);
      i_clr_cnt = 1'b1;
      send_prbs(1, '0);
      i_clr_cnt = 1'b0;
      chk("clr_pulse", 32'(o_err_word), 32'd1);
      chk("clr_err",   o_err_cnt,  32'd0);
      chk("clr_word",  o_word_cnt, 32'd0);
      chk("clr_lock",  32'(o_lock), 32'd1);

      // Pattern select change; PRBS7 data never locks as PRBS15.
      send_prbs(3, '0);
      wc0 = o_word_cnt;
      i_cfg_prbs_sel = 2'd0;
      reseed();
      send_prbs(1, '0);
      chk("sel_unlock", 32'(o_lock), 32'd0);
      chk("sel_keep",   o_word_cnt, wc0);
      wait_lock("prbs7_lock", 30, n);
      i_cfg_prbs_sel = 2'd1;
      saw_lock = 0;
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] w;
         gen_word(2'd0, w);
         i_en  = 1'b1;
         i_drx = w ^ {W{i_cfg_inv}};
         tick();
         if (o_lock) saw_lock = 1;
      end
      chk("prbs7_as_15", 32'(saw_lock), 32'd0);

      // Random enable gaps, then reset mid-stream.
      i_cfg_prbs_sel = 2'd2;
      i_cfg_inv = 1'b0;
      reseed();
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(1, 0) == 1) send_prbs(1, '0);
         else idle(1);
      end
      chk("gap_lock", 32'(o_lock), 32'd1);
      send_prbs(2, '0);
      i_rst = 1'b1;
      send_prbs(1, '0);
      i_rst = 1'b0;
      chk("mid_rst_lock", 32'(o_lock),     32'd0);
      chk("mid_rst_errw", 32'(o_err_word), 32'd0);
      chk("mid_rst_err",  o_err_cnt,       32'd0);
      chk("mid_rst_word", o_word_cnt,      32'd0);
      idle(2);
      chk("post_rst_quiet", o_word_cnt, 32'd0);
      wait_lock("post_rst_relock", 40, n);
      send_prbs(5, '0);
      chk("post_rst_words", o_word_cnt, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
